// File: rtl/gray_bin2x2_downscaler.sv
// 2x2 box-average downscaler for replicated-gray AXI4-Stream video.
// Optional build macro GRAY_BIN_ROUND_EN selects round-half-up; default truncates.
module gray_bin2x2_downscaler #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIX_W        = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_axis_tvalid,
  input  logic [3*PIX_W-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tuser,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  output logic [3*PIX_W-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  input  logic               m_axis_tready,
  output logic               line_err
);

  localparam int              XW     = $clog2(IMAGE_WIDTH);
  localparam int              HALF_W = IMAGE_WIDTH / 2;
  localparam logic [XW-1:0]   X_LAST = XW'(IMAGE_WIDTH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} sync_state_e;

  sync_state_e      state_q, state_d;
  logic [XW-1:0]    x_q, x_d, eff_x;
  logic             r_q, r_d, eff_r;
  logic [PIX_W-1:0] p0_q, p0_d, pix;
  logic             first_q, first_d;
  logic             line_err_q, line_err_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic [PIX_W-1:0] avg_q, avg_d, avg;
  logic [PIX_W:0]   pair;
  logic [PIX_W+1:0] sum, sum_adj;
  logic             accept, active, at_last;

  logic [PIX_W:0]   linebuf [HALF_W];
  logic [PIX_W:0]   lb_rd_q;
  logic             lb_we, lb_re;
  logic [XW-2:0]    lb_addr;

  logic             unused_ok;
  assign unused_ok = ^{s_axis_tdata[3*PIX_W-1:PIX_W], 1'(IMAGE_HEIGHT % 2)};

  assign s_axis_tready = ~m_valid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pix           = s_axis_tdata[PIX_W-1:0];

  // An SOF beat always restarts the block grid at the top-left pixel.
  assign eff_x   = s_axis_tuser ? '0 : x_q;
  assign eff_r   = s_axis_tuser ? 1'b0 : r_q;
  assign at_last = (eff_x == X_LAST);
  assign active  = accept & (s_axis_tuser | (state_q == LOCKED));
  assign lb_addr = eff_x[XW-1:1];

  assign pair = {1'b0, p0_q} + {1'b0, pix};
  assign sum  = {1'b0, lb_rd_q} + {1'b0, pair};
`ifdef GRAY_BIN_ROUND_EN
  assign sum_adj = sum + (PIX_W+2)'(2);
`else
  assign sum_adj = sum;
`endif
  assign avg = sum_adj[PIX_W+1:2];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    r_d        = r_q;
    p0_d       = p0_q;
    first_d    = first_q;
    line_err_d = line_err_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    avg_d      = avg_q;
    lb_we      = 1'b0;
    lb_re      = 1'b0;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (active) begin
      if (s_axis_tuser) begin
        state_d = LOCKED;
        first_d = 1'b1;
      end
      if (s_axis_tlast != at_last) begin
        line_err_d = 1'b1;
      end
      x_d = at_last ? '0 : eff_x + 1'b1;
      r_d = at_last ? ~eff_r : eff_r;

      if (!eff_x[0]) begin
        p0_d  = pix;
        lb_re = eff_r;
      end else if (!eff_r) begin
        lb_we = 1'b1;
      end else begin
        // Loading here may coincide with the previous beat leaving: no bubble.
        m_valid_d = 1'b1;
        avg_d     = avg;
        m_last_d  = at_last;
        m_user_d  = first_q;
        first_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= HUNT;
      x_q        <= '0;
      r_q        <= 1'b0;
      p0_q       <= '0;
      first_q    <= 1'b0;
      line_err_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      avg_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      r_q        <= r_d;
      p0_q       <= p0_d;
      first_q    <= first_d;
      line_err_q <= line_err_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      avg_q      <= avg_d;
    end
  end

  // Even-row pair sums; the read is launched on the even-x beat of the odd row.
  always_ff @(posedge aclk) begin
    if (lb_we) begin
      linebuf[lb_addr] <= pair;
    end
    if (lb_re) begin
      lb_rd_q <= linebuf[lb_addr];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rep
      assign m_axis_tdata[gi*PIX_W +: PIX_W] = avg_q;
    end
  endgenerate

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign line_err      = line_err_q;

endmodule

// File: tb/tb_gray_bin2x2_downscaler.sv
// Self-checking bench for gray_bin2x2_downscaler on an 8x4 frame.
module tb_gray_bin2x2_downscaler;

  localparam int W = 8;
  localparam int H = 4;
  localparam int P = 8;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [3*P-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [3*P-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tuser;
  logic          m_tready = 1'b1;
  logic          line_err;

  always #5 aclk = ~aclk;

  gray_bin2x2_downscaler #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIX_W(P)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready), .line_err(line_err)
  );

  typedef struct {
    logic [3*P-1:0] data;
    logic           last;
    logic           user;
  } beat_t;

  typedef struct {
    int unsigned    a, b, c, d;
    logic [3*P-1:0] exp_round;
    logic [3*P-1:0] exp_trunc;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    frame_pix [H][W];
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int avg4(input int s);
`ifdef GRAY_BIN_ROUND_EN
    return (s + 2) / 4;
`else
    return s / 4;
`endif
  endfunction

  function automatic logic [3*P-1:0] rep(input int v);
    logic [P-1:0] g;
    g = P'(v);
    return {g, g, g};
  endfunction

  // Reference: each output is the mean of one 2x2 block, raster order.
  task automatic build_expected();
    beat_t e;
    for (int by = 0; by < H / 2; by++) begin
      for (int bx = 0; bx < W / 2; bx++) begin
        e.data = rep(avg4(frame_pix[2*by][2*bx] + frame_pix[2*by][2*bx+1] +
                          frame_pix[2*by+1][2*bx] + frame_pix[2*by+1][2*bx+1]));
        e.last = (bx == W / 2 - 1);
        e.user = (by == 0 && bx == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame_pix[y][x] = int'($urandom_range(0, 255));
  endtask

  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  beat_t held;
  logic  hold_chk = 1'b0;
  always @(negedge aclk) begin
    if (aresetn && hold_chk) begin
      check("hold_valid", 32'(m_tvalid), 32'd1);
      check("hold_data", 32'(m_tdata), 32'(held.data));
      check("hold_flags", {30'd0, m_tlast, m_tuser}, {30'd0, held.last, held.user});
    end
    if (aresetn && m_tvalid && m_tready) begin
      got_q.push_back('{data: m_tdata, last: m_tlast, user: m_tuser});
    end
    hold_chk = aresetn && m_tvalid && !m_tready;
    held     = '{data: m_tdata, last: m_tlast, user: m_tuser};
  end

  task automatic send_beat(input int g, input logic last, input logic user);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = {8'($urandom), 8'($urandom), 8'(g)};
    s_tlast  = last;
    s_tuser  = user;
    n = 0;
    while (!s_tready && n < 1000) begin
      @(posedge aclk); #2;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: s_axis_tready stuck at 0, expected 1");
    end
    @(posedge aclk); #2;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int bad_last_x);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_beat(frame_pix[y][x], (x == W - 1) || (y == 0 && x == bad_last_x),
                  (y == 0 && x == 0));
  endtask

  task automatic drain();
    ready_mode = 0;
    repeat (12) @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #2;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_flags", {30'd0, m_tlast, m_tuser}, 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    aresetn = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_outputs(input string name);
    int n;
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_flags%0d", name, i), {30'd0, got_q[i].last, got_q[i].user},
            {30'd0, exp_q[i].last, exp_q[i].user});
    end
    $display("%s: %0d outputs compared, line_err=%0d", name, n, line_err);
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[6];
  logic [3*P-1:0] first_data;
  int n_wait;

  initial begin
    vecs[0] = '{10, 11, 12, 12, 24'h0B0B0B, 24'h0B0B0B};
    vecs[1] = '{10, 11, 11, 12, 24'h0B0B0B, 24'h0B0B0B};
    vecs[2] = '{1, 1, 1, 2, 24'h010101, 24'h010101};
    vecs[3] = '{1, 2, 2, 2, 24'h020202, 24'h010101};
    vecs[4] = '{255, 255, 255, 255, 24'hFFFFFF, 24'hFFFFFF};
    vecs[5] = '{0, 0, 1, 2, 24'h010101, 24'h000000};

    // Reset state and idle ready
    do_reset();
    check("rst_s_tready", 32'(s_tready), 32'd1);

    // Flat 0x64 frame
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame_pix[y][x] = 100;
    build_expected();
    send_frame(-1);
    drain();
    check("flat_line_err", 32'(line_err), 32'd0);
    compare_outputs("flat");

    // Table of 2x2 blocks placed at the top-left corner
    for (int i = 0; i < 6; i++) begin
      fill_random();
      frame_pix[0][0] = int'(vecs[i].a);
      frame_pix[0][1] = int'(vecs[i].b);
      frame_pix[1][0] = int'(vecs[i].c);
      frame_pix[1][1] = int'(vecs[i].d);
      send_frame(-1);
      drain();
      check($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'(NOUT));
      if (got_q.size() > 0) begin
`ifdef GRAY_BIN_ROUND_EN
        check($sformatf("vec%0d_avg", i), 32'(got_q[0].data), 32'(vecs[i].exp_round));
`else
        check($sformatf("vec%0d_avg", i), 32'(got_q[0].data), 32'(vecs[i].exp_trunc));
`endif
      end
      $display("vec%0d: block %0d,%0d,%0d,%0d -> %h", i, vecs[i].a, vecs[i].b,
               vecs[i].c, vecs[i].d, (got_q.size() > 0) ? got_q[0].data : 24'h0);
      got_q.delete();
    end

    // Random frames under random backpressure
    for (int f = 0; f < 3; f++) begin
      fill_random();
      build_expected();
      ready_mode = 1;
      send_frame(-1);
      drain();
      compare_outputs($sformatf("rand%0d", f));
    end

    // Downstream stalled 5 cycles with an output pending
    fill_random();
    build_expected();
    ready_mode = 2;
    fork
      send_frame(-1);
      begin
        n_wait = 0;
        while (!m_tvalid && n_wait < 500) begin
          @(negedge aclk);
          n_wait++;
        end
        check("stall_seen_valid", 32'(m_tvalid), 32'd1);
        first_data = m_tdata;
        repeat (5) begin
          @(negedge aclk);
          check("stall_s_tready", 32'(s_tready), 32'd0);
          check("stall_data", 32'(m_tdata), 32'(first_data));
        end
        ready_mode = 0;
      end
    join
    drain();
    compare_outputs("stall");

    // Junk beats before SOF are dropped
    do_reset();
    fill_random();
    build_expected();
    for (int i = 0; i < 3; i++)
      send_beat(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_frame(-1);
    drain();
    check("junk_line_err", 32'(line_err), 32'd0);
    compare_outputs("junk");

    // Early tlast sets sticky line_err without disturbing data
    fill_random();
    build_expected();
    send_frame(5);
    drain();
    check("tlast_err_set", 32'(line_err), 32'd1);
    compare_outputs("tlast_err");
    fill_random();
    build_expected();
    send_frame(-1);
    drain();
    check("tlast_err_sticky", 32'(line_err), 32'd1);
    compare_outputs("after_err");

    // SOF in the middle of row 1 abandons the partial block
    do_reset();
    fill_random();
    exp_q.push_back('{data: rep(avg4(frame_pix[0][0] + frame_pix[0][1] +
                                     frame_pix[1][0] + frame_pix[1][1])),
                      last: 1'b0, user: 1'b1});
    for (int x = 0; x < W; x++)
      send_beat(frame_pix[0][x], x == W - 1, x == 0);
    for (int x = 0; x < 3; x++)
      send_beat(frame_pix[1][x], 1'b0, 1'b0);
    fill_random();
    build_expected();
    send_frame(-1);
    drain();
    check("resync_line_err", 32'(line_err), 32'd0);
    compare_outputs("resync");

    // Reset pulse while an output is held, then back to HUNT
    fill_random();
    ready_mode = 2;
    for (int x = 0; x < W; x++)
      send_beat(frame_pix[0][x], x == W - 1, x == 0);
    send_beat(frame_pix[1][0], 1'b0, 1'b0);
    send_beat(frame_pix[1][1], 1'b0, 1'b0);
    check("pre_rst_valid", 32'(m_tvalid), 32'd1);
    aresetn = 1'b0;
    @(posedge aclk); #2;
    check("midrst_valid", 32'(m_tvalid), 32'd0);
    check("midrst_data", 32'(m_tdata), 32'd0);
    aresetn = 1'b1;
    ready_mode = 0;
    got_q.delete();
    for (int i = 0; i < 4; i++)
      send_beat(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    drain();
    check("hunt_no_output", 32'(got_q.size()), 32'd0);
    check("hunt_line_err", 32'(line_err), 32'd0);
    fill_random();
    build_expected();
    send_frame(-1);
    drain();
    compare_outputs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
